mnist_nn_spi_slave: RTL
=======================

// Module: mnist_nn_spi_slave
// PURPOSE
//  SPI slave: receiving end of the SPI bus, opposite side of the mnist_nn SPI master.
//  Mode 0 (CPOL=0, CPHA=0), MSB first, 8-bit frames. Lets a host MCU stream bytes in and out.
//  SCLK/SS_n/MOSI are oversampled in the clk domain. The CPU-side register port is
//  register-compatible with the master (same addresses, status bits and two-cycle access).
// PARAMETERS
//  DATABITS     8   frame width; only 8 is verified
//  SYNC_STAGES  2   synchronizer flops on SCLK, SS_n and MOSI (minimum 2)
// PORTS
//  clk            in   1   system clock, 50 MHz
//  reset_n        in   1   asynchronous active-low reset
//  SCLK           in   1   SPI clock from the bus master
//  SS_n           in   1   slave select, active low
//  MOSI           in   1   serial data in
//  MISO           out  1   serial data out (registered)
//  MISO_oe        out  1   MISO output enable; equals the synchronized ~SS_n
//  mem_addr       in   3   register address: 0 rxdata(r), 1 txdata(w), 2 status(r/w), 3 control(r/w), 6 eop value(r/w)
//  data_from_cpu  in   16  write data
//  data_to_cpu    out  16  read data, registered
//  read_n         in   1   active-low read
//  write_n        in   1   active-low write
//  spi_select     in   1   chip select for the register port
//  irq            out  1   registered interrupt request
//  dataavailable  out  1   = RRDY
//  readyfordata   out  1   = TRDY
//  endofpacket    out  1   = EOP
// BEHAVIOUR
//  Reset values: every flop 0, except the SS_n synchronizer (1) and bitcnt (0).
//   Outputs at reset: MISO=0, MISO_oe=0, data_to_cpu=0, irq=0.
//  Synchronizers and edges:
//   - rise/fall = one-cycle pulses from the last two synchronized SCLK samples.
//   - ss_act = synchronized ~SS_n; ss_start = its rising edge.
//   - Bus constraints: fSCLK <= clk/8; SS_n low to first SCLK rise >= 4 clk.
//  Frame load (at ss_start, or after the 8th rise while ss_act):
//   - shift_reg <= tx_holding if primed, else 8'h00; primed <= 0.
//   - At ss_start, MISO <= loaded bit 7 in the same cycle.
//  Bit transfer:
//   - On rise: shift_reg <= {shift_reg[6:0], MOSI_s}; bitcnt++.
//   - On fall: MISO <= shift_reg[7].
//  8th rise:
//   - rx_holding <= shifted byte; RRDY <= 1; ROE <= 1 if RRDY was already 1.
//   - bitcnt <= 0; the frame-load rule applies in the same cycle (back-to-back bytes under one SS_n).
//  SS_n deassert mid-byte: partial byte discarded; bitcnt <= 0; RRDY unchanged; tx_holding kept.
//  Register port (same two-cycle access as the master):
//   - Strobe fires on the first cycle of spi_select & ~read_n / ~write_n.
//   - data_to_cpu is registered: valid 1 cycle after the read strobe.
//   - Side effects occur on the second cycle.
//  Data registers:
//   - Read of addr 0 clears RRDY.
//   - Write of addr 1 when TRDY (=~primed): tx_holding <= data[7:0], primed <= 1.
//   - Write of addr 1 when ~TRDY: data dropped, TOE <= 1.
//   - TMT = ~primed & ~(ss_act & bitcnt!=0).
//  Status / control / EOP:
//   - status = {EOP, E=ROE|TOE, RRDY, TRDY, TMT, TOE, ROE, 3'b0}; any write to addr 2 clears EOP, RRDY, ROE, TOE.
//   - control bits 9..3 = irq enables {iEOP, iE, iRRDY, iTRDY, 0, iTOE, iROE}.
//   - irq <= OR(flag & enable), registered (1-cycle latency).
//   - EOP <= 1 when a received byte == eop_value[7:0], or when a written tx byte == eop_value[7:0].
//  Simultaneous events:
//   - Byte completion vs rx read or status write in the same cycle: the set wins (RRDY/ROE stay 1).
//   - tx write in the same cycle as a frame load with primed=0: load sends 8'h00; the write primes the holding register.
// STRUCTURE
//  - Shared package mnist_nn_spi_pkg: register address constants, status/control bit
//    positions, DATABITS default. The same package is used by the master.
//  - Sub-module mnist_nn_spi_sync: SYNC_STAGES synchronizer plus rise/fall detect,
//    instantiated once per SPI input (SCLK, SS_n, MOSI).
// TESTING
//  1. Write 0xA5 to txdata, then master sends 0x3C under SS_n -> MISO bits 1,0,1,0,0,1,0,1; RRDY=1; rxdata reads 0x3C; RRDY then 0.
//  2. Two bytes 0x11, 0x22 under one SS_n with 0x5A, 0x6B pre-queued (second written after TRDY) -> MISO shows 0x5A then 0x6B; second rx sets ROE if 0x11 unread.
//  3. No tx primed, master sends 0xFF -> MISO all 0; rx 0xFF; TMT=1 after the frame.
//  4. Write txdata twice with no bus activity -> second write sets TOE; E=1; irq=1 two cycles later with iTOE set; status write clears it.
//  5. SS_n released after 5 SCLK rises, then a full frame 0x81 -> only 0x81 is received; RRDY set once.
//  6. eop_value=0x0D, receive 0x0D -> EOP=1, endofpacket=1; reset_n pulsed mid-frame -> all flags 0, MISO=0, next frame OK.

Source files
------------

// File: rtl/mnist_nn_spi_pkg.sv
// Shared definitions for the mnist_nn SPI master and slave: register map,
// status word layout and default parameters.
package mnist_nn_spi_pkg;

    localparam int DATABITS_DEF    = 8;
    localparam int SYNC_STAGES_DEF = 2;

    typedef enum logic [2:0] {
        REG_RXDATA  = 3'd0,
        REG_TXDATA  = 3'd1,
        REG_STATUS  = 3'd2,
        REG_CONTROL = 3'd3,
        REG_EOP     = 3'd6
    } reg_addr_e;

    // Field order matches status bits 9..3; control uses the same positions.
    typedef struct packed {
        logic eop;
        logic e;
        logic rrdy;
        logic trdy;
        logic tmt;
        logic toe;
        logic roe;
    } status_t;

    // TMT has no interrupt enable.
    localparam logic [6:0] CTRL_MASK = 7'b111_1011;

    function automatic logic [15:0] pack_status(input status_t s);
        return {6'b0, s, 3'b000};
    endfunction

endpackage

// File: rtl/mnist_nn_spi_slave_if.sv
// Signal bundle for the SPI slave: serial bus pins plus the CPU register port.
// CPU port: an access is spi_select with read_n/write_n low for two clk cycles;
// the first cycle is the strobe, read data is valid one cycle after it.
interface mnist_nn_spi_slave_if;
    logic        SCLK;
    logic        SS_n;
    logic        MOSI;
    logic        MISO;
    logic        MISO_oe;
    logic [2:0]  mem_addr;
    logic [15:0] data_from_cpu;
    logic [15:0] data_to_cpu;
    logic        read_n;
    logic        write_n;
    logic        spi_select;
    logic        irq;
    logic        dataavailable;
    logic        readyfordata;
    logic        endofpacket;

    modport master (
        output SCLK, SS_n, MOSI, mem_addr, data_from_cpu, read_n, write_n, spi_select,
        input  MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata, endofpacket
    );

    modport slave (
        input  SCLK, SS_n, MOSI, mem_addr, data_from_cpu, read_n, write_n, spi_select,
        output MISO, MISO_oe, data_to_cpu, irq, dataavailable, readyfordata, endofpacket
    );
endinterface

// File: rtl/mnist_nn_spi_sync.sv
// Multi-stage synchronizer for one SPI pin with rise/fall pulses taken from
// the last two synchronized samples.
module mnist_nn_spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o,
    output logic fall_o
);
    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], d_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign q_o    = sync_q[STAGES-1];
    assign rise_o = sync_q[STAGES-1] & ~prev_q;
    assign fall_o = ~sync_q[STAGES-1] & prev_q;
endmodule

// File: rtl/mnist_nn_spi_slave.sv
// Mode-0 SPI slave, MSB first, oversampled in the clk domain, with a CPU
// register port that mirrors the mnist_nn SPI master.
module mnist_nn_spi_slave
    import mnist_nn_spi_pkg::*;
#(
    parameter int DATABITS    = DATABITS_DEF,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        SCLK,
    input  logic        SS_n,
    input  logic        MOSI,
    output logic        MISO,
    output logic        MISO_oe,
    input  logic [2:0]  mem_addr,
    input  logic [15:0] data_from_cpu,
    output logic [15:0] data_to_cpu,
    input  logic        read_n,
    input  logic        write_n,
    input  logic        spi_select,
    output logic        irq,
    output logic        dataavailable,
    output logic        readyfordata,
    output logic        endofpacket
);
    localparam int CW = $clog2(DATABITS + 1);

    logic sclk_lvl_unused, sclk_rise, sclk_fall;
    logic ss_lvl, ss_rise_unused, ss_fall;
    logic mosi_lvl, mosi_rise_unused, mosi_fall_unused;

    mnist_nn_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk(clk), .reset_n(reset_n), .d_i(SCLK),
        .q_o(sclk_lvl_unused), .rise_o(sclk_rise), .fall_o(sclk_fall));
    mnist_nn_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_ss (
        .clk(clk), .reset_n(reset_n), .d_i(SS_n),
        .q_o(ss_lvl), .rise_o(ss_rise_unused), .fall_o(ss_fall));
    mnist_nn_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
        .clk(clk), .reset_n(reset_n), .d_i(MOSI),
        .q_o(mosi_lvl), .rise_o(mosi_rise_unused), .fall_o(mosi_fall_unused));

    logic [DATABITS-1:0] shift_q, shift_d, tx_q, tx_d, rx_q, rx_d;
    logic [CW-1:0]       bitcnt_q, bitcnt_d;
    logic                primed_q, primed_d, rrdy_q, rrdy_d, roe_q, roe_d;
    logic                toe_q, toe_d, eop_q, eop_d, miso_q, miso_d, irq_q, irq_d;
    logic [6:0]          ctrl_q, ctrl_d;
    logic [15:0]         eop_val_q, eop_val_d, rdata_q, rdata_d, wr_data_q;
    logic [2:0]          wr_addr_q;
    logic                rd_q, wr_q, rx_rd_fx_q, wr_fx_q;

    logic ss_act, ss_start, bit_rise, last_bit, frame_load;
    logic rd_stb, wr_stb, tx_wr, status_wr;
    logic [DATABITS-1:0] rx_byte, load_byte;
    status_t             st;
    logic [15:0]         status_word;

    assign ss_act     = ~ss_lvl;
    assign ss_start   = ss_fall;
    assign bit_rise   = ss_act & sclk_rise;
    assign last_bit   = bit_rise & (bitcnt_q == CW'(DATABITS - 1));
    assign frame_load = ss_start | last_bit;
    assign rx_byte    = {shift_q[DATABITS-2:0], mosi_lvl};
    assign load_byte  = primed_q ? tx_q : '0;

    // Strobe on the first cycle of an access, side effects one cycle later.
    assign rd_stb    = spi_select & ~read_n & ~rd_q;
    assign wr_stb    = spi_select & ~write_n & ~wr_q;
    assign tx_wr     = wr_fx_q & (wr_addr_q == REG_TXDATA);
    assign status_wr = wr_fx_q & (wr_addr_q == REG_STATUS);

    always_comb begin
        st.eop  = eop_q;
        st.e    = roe_q | toe_q;
        st.rrdy = rrdy_q;
        st.trdy = ~primed_q;
        st.tmt  = ~primed_q & ~(ss_act & (bitcnt_q != '0));
        st.toe  = toe_q;
        st.roe  = roe_q;
        status_word = pack_status(st);
        irq_d = |(status_word[9:3] & ctrl_q);
    end

    always_comb begin
        shift_d   = shift_q;
        bitcnt_d  = bitcnt_q;
        miso_d    = miso_q;
        rx_d      = rx_q;
        tx_d      = tx_q;
        primed_d  = primed_q;
        rrdy_d    = rrdy_q;
        roe_d     = roe_q;
        toe_d     = toe_q;
        eop_d     = eop_q;
        ctrl_d    = ctrl_q;
        eop_val_d = eop_val_q;
        rdata_d   = rdata_q;

        if (frame_load)    shift_d = load_byte;
        else if (bit_rise) shift_d = rx_byte;

        if (!ss_act || last_bit) bitcnt_d = '0;
        else if (bit_rise)        bitcnt_d = bitcnt_q + CW'(1);

        if (ss_start)                miso_d = load_byte[DATABITS-1];
        else if (ss_act && sclk_fall) miso_d = shift_q[DATABITS-1];

        if (last_bit) rx_d = rx_byte;

        // Clears first so that a simultaneous byte completion wins.
        if (rx_rd_fx_q || status_wr) rrdy_d = 1'b0;
        if (status_wr) begin
            roe_d = 1'b0;
            toe_d = 1'b0;
            eop_d = 1'b0;
        end
        if (last_bit) begin
            rrdy_d = 1'b1;
            if (rrdy_q) roe_d = 1'b1;
            if (rx_byte == eop_val_q[DATABITS-1:0]) eop_d = 1'b1;
        end

        if (frame_load) primed_d = 1'b0;
        if (tx_wr) begin
            if (primed_q) begin
                toe_d = 1'b1;
            end else begin
                tx_d     = wr_data_q[DATABITS-1:0];
                primed_d = 1'b1;
            end
            if (wr_data_q[DATABITS-1:0] == eop_val_q[DATABITS-1:0]) eop_d = 1'b1;
        end

        if (wr_fx_q && wr_addr_q == REG_CONTROL) ctrl_d    = wr_data_q[9:3] & CTRL_MASK;
        if (wr_fx_q && wr_addr_q == REG_EOP)     eop_val_d = wr_data_q;

        if (rd_stb) begin
            case (mem_addr)
                REG_RXDATA:  rdata_d = 16'(rx_q);
                REG_STATUS:  rdata_d = status_word;
                REG_CONTROL: rdata_d = {6'b0, ctrl_q, 3'b000};
                REG_EOP:     rdata_d = eop_val_q;
                default:     rdata_d = '0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            shift_q    <= '0;
            bitcnt_q   <= '0;
            miso_q     <= 1'b0;
            rx_q       <= '0;
            tx_q       <= '0;
            primed_q   <= 1'b0;
            rrdy_q     <= 1'b0;
            roe_q      <= 1'b0;
            toe_q      <= 1'b0;
            eop_q      <= 1'b0;
            irq_q      <= 1'b0;
            ctrl_q     <= '0;
            eop_val_q  <= '0;
            rdata_q    <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            rx_rd_fx_q <= 1'b0;
            wr_fx_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
        end else begin
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            miso_q     <= miso_d;
            rx_q       <= rx_d;
            tx_q       <= tx_d;
            primed_q   <= primed_d;
            rrdy_q     <= rrdy_d;
            roe_q      <= roe_d;
            toe_q      <= toe_d;
            eop_q      <= eop_d;
            irq_q      <= irq_d;
            ctrl_q     <= ctrl_d;
            eop_val_q  <= eop_val_d;
            rdata_q    <= rdata_d;
            rd_q       <= spi_select & ~read_n;
            wr_q       <= spi_select & ~write_n;
            rx_rd_fx_q <= rd_stb & (mem_addr == REG_RXDATA);
            wr_fx_q    <= wr_stb;
            if (wr_stb) begin
                wr_addr_q <= mem_addr;
                wr_data_q <= data_from_cpu;
            end
        end
    end

    assign MISO          = miso_q;
    assign MISO_oe       = ss_act;
    assign data_to_cpu   = rdata_q;
    assign irq           = irq_q;
    assign dataavailable = rrdy_q;
    assign readyfordata  = ~primed_q;
    assign endofpacket   = eop_q;
endmodule
